// File: rtl/hv_pkg.sv
// hv_pkg: shared types and default widths for the hypervector element-wise ALU.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the operation enum, the controller state enum and the default
// address/data widths used as parameter defaults by hv_elementwise_alu.

package hv_pkg;

    localparam int HV_ADDR_W_DEF = 21;
    localparam int HV_DATA_W_DEF = 32;

    // Encoding matches the 2-bit mode input of the top level.
    typedef enum logic [1:0] {
        ADD    = 2'd0,
        SUB    = 2'd1,
        MUL    = 2'd2,
        PASS_A = 2'd3
    } hv_mode_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_B  = 3'd2,
        CAPT  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5
    } hv_state_e;

endpackage

// File: rtl/hv_cut_alu.sv
// hv_cut_alu: computes f(a,b) for the selected mode and clips it to [CUT_NEG, CUT_POS].
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is valid whenever the inputs are.
//
// Ports:
//   mode [1:0]   operation select (ADD, SUB, MUL, PASS_A)
//   a, b         signed operands, DATA_W bits each
//   res          clipped result, DATA_W bits
//   sat          high when the unclipped value lies outside [CUT_NEG, CUT_POS]

module hv_cut_alu
    import hv_pkg::*;
#(
    parameter int DATA_W  = HV_DATA_W_DEF,
    parameter int CUT_NEG = -1,
    parameter int CUT_POS = 1
) (
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] res,
    output logic              sat
);

    // One common working width wide enough for the full product; sums and
    // differences need only DATA_W+1 bits and therefore fit exactly as well.
    localparam int W = 2 * DATA_W;

    localparam logic signed [W-1:0] LO_W = W'(CUT_NEG);
    localparam logic signed [W-1:0] HI_W = W'(CUT_POS);

    logic signed [W-1:0] a_x;
    logic signed [W-1:0] b_x;
    logic signed [W-1:0] full;
    logic signed [W-1:0] clipped;

    always_comb begin
        a_x     = W'($signed(a));
        b_x     = W'($signed(b));
        full    = a_x;
        case (hv_mode_e'(mode))
            ADD:     full = a_x + b_x;
            SUB:     full = a_x - b_x;
            MUL:     full = a_x * b_x;
            default: full = a_x;
        endcase

        sat     = 1'b0;
        clipped = full;
        if (full < LO_W) begin
            sat     = 1'b1;
            clipped = LO_W;
        end else if (full > HI_W) begin
            sat     = 1'b1;
            clipped = HI_W;
        end

        // The clip bounds fit in DATA_W, so dropping the upper bits is lossless.
        res = clipped[DATA_W-1:0];
    end

endmodule

// File: rtl/hv_elementwise_alu.sv
// hv_elementwise_alu: C[i] = clip(f(A[i], B[i])) over HYPERVECTOR_DIMENSIONS elements in memory.
// Latency: 4 cycles per element; done pulses 4*HYPERVECTOR_DIMENSIONS+1 cycles after valid is sampled.
// Backpressure: none; valid is only sampled in IDLE and ignored while busy.
//
// Ports:
//   clk, reset_n              rising-edge clock, synchronous active-low reset
//   valid, mode, addr_a/b/c   start request, operation and base addresses (sampled in IDLE)
//   raddress / data_rd        memory read port, data returns one cycle after the address
//   we_n, waddress, data_wr   memory write port, active-low strobe
//   busy, done                busy outside IDLE; one-cycle completion pulse
//   sat_count                 only with HV_SAT_COUNT_EN: number of clipped writes in the last run
//
// Optional feature macro: HV_SAT_COUNT_EN.

module hv_elementwise_alu
    import hv_pkg::*;
#(
    parameter int HYPERVECTOR_DIMENSIONS = 1000,
    parameter int ADDR_W                 = HV_ADDR_W_DEF,
    parameter int DATA_W                 = HV_DATA_W_DEF,
    parameter int CUT_NEG                = -1,
    parameter int CUT_POS                = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              valid,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [ADDR_W-1:0] addr_c,
    output logic [ADDR_W-1:0] raddress,
    input  logic [DATA_W-1:0] data_rd,
    output logic              we_n,
    output logic [ADDR_W-1:0] waddress,
    output logic [DATA_W-1:0] data_wr,
    output logic              busy,
    output logic              done
`ifdef HV_SAT_COUNT_EN
    ,
    output logic [ADDR_W:0]   sat_count
`endif
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(HYPERVECTOR_DIMENSIONS - 1);
    localparam logic [ADDR_W-1:0] IDX_ONE  = ADDR_W'(1);

    hv_state_e         state_q, state_d;
    logic [1:0]        mode_q, mode_d;
    logic [ADDR_W-1:0] addr_a_q, addr_a_d;
    logic [ADDR_W-1:0] addr_b_q, addr_b_d;
    logic [ADDR_W-1:0] addr_c_q, addr_c_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;

    logic [DATA_W-1:0] alu_res;
    logic              alu_sat;

    hv_cut_alu #(
        .DATA_W  (DATA_W),
        .CUT_NEG (CUT_NEG),
        .CUT_POS (CUT_POS)
    ) u_cut_alu (
        .mode (mode_q),
        .a    (a_q),
        .b    (b_q),
        .res  (alu_res),
        .sat  (alu_sat)
    );

`ifdef HV_SAT_COUNT_EN
    localparam logic [ADDR_W:0] SAT_ONE = (ADDR_W + 1)'(1);

    logic [ADDR_W:0] sat_count_q, sat_count_d;

    assign sat_count = sat_count_q;
`else
    logic sat_flag_unused;

    assign sat_flag_unused = alu_sat;
`endif

    assign busy = (state_q != IDLE);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        addr_a_d = addr_a_q;
        addr_b_d = addr_b_q;
        addr_c_d = addr_c_q;
        idx_d    = idx_q;
        a_d      = a_q;
        b_d      = b_q;
`ifdef HV_SAT_COUNT_EN
        sat_count_d = sat_count_q;
`endif
        raddress = '0;
        waddress = '0;
        data_wr  = '0;
        we_n     = 1'b1;
        done     = 1'b0;

        case (state_q)
            IDLE: begin
                if (valid) begin
                    mode_d   = mode;
                    addr_a_d = addr_a;
                    addr_b_d = addr_b;
                    addr_c_d = addr_c;
                    idx_d    = '0;
`ifdef HV_SAT_COUNT_EN
                    sat_count_d = '0;
`endif
                    state_d  = RD_A;
                end
            end

            RD_A: begin
                raddress = addr_a_q + idx_q;
                state_d  = RD_B;
            end

            // data_rd now carries A[idx] requested in RD_A.
            RD_B: begin
                raddress = addr_b_q + idx_q;
                a_d      = data_rd;
                state_d  = CAPT;
            end

            // data_rd now carries B[idx] requested in RD_B.
            CAPT: begin
                b_d     = data_rd;
                state_d = WRITE;
            end

            WRITE: begin
                we_n     = 1'b0;
                waddress = addr_c_q + idx_q;
                data_wr  = alu_res;
`ifdef HV_SAT_COUNT_EN
                if (alu_sat) begin
                    sat_count_d = sat_count_q + SAT_ONE;
                end
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    state_d = RD_A;
                end
            end

            // valid is deliberately not looked at here; a new run can only
            // start from IDLE on the following cycle.
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mode_q   <= '0;
            addr_a_q <= '0;
            addr_b_q <= '0;
            addr_c_q <= '0;
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
`ifdef HV_SAT_COUNT_EN
            sat_count_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            addr_a_q <= addr_a_d;
            addr_b_q <= addr_b_d;
            addr_c_q <= addr_c_d;
            idx_q    <= idx_d;
            a_q      <= a_d;
            b_q      <= b_d;
`ifdef HV_SAT_COUNT_EN
            sat_count_q <= sat_count_d;
`endif
        end
    end

endmodule

// File: doc/hv_elementwise_alu.md
HV_ELEMENTWISE_ALU -- requirements
Module: hv_elementwise_alu

Interface
REQ-001 Parameter HYPERVECTOR_DIMENSIONS, default 1000: elements per operand vector; legal range 1..2^ADDR_W.
REQ-002 Parameter ADDR_W, default 21: memory address width.
REQ-003 Parameter DATA_W, default 32: signed element width, one element per memory word.
REQ-004 Parameter CUT_NEG, default -1: lower clip bound, signed; CUT_NEG <= CUT_POS.
REQ-005 Parameter CUT_POS, default 1: upper clip bound, signed.
REQ-006 clk  in  1  single clock; all logic is rising-edge.
REQ-007 reset_n  in  1  reset, synchronous, active-low.
REQ-008 valid  in  1  start request, sampled only in IDLE.
REQ-009 mode  in  2  operation: 0 ADD, 1 SUB (a-b), 2 MUL, 3 PASS_A.
REQ-010 addr_a, addr_b, addr_c  in  ADDR_W each  base addresses of operand A, operand B and result C.
REQ-011 raddress  out  ADDR_W  memory read address; read data returns on data_rd one cycle later.
REQ-012 data_rd  in  DATA_W  memory read data.
REQ-013 we_n  out  1  memory write strobe, active-low.
REQ-014 waddress  out  ADDR_W  memory write address.
REQ-015 data_wr  out  DATA_W  memory write data.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 done  out  1  one-cycle completion pulse.

Function
REQ-018 FSM states: IDLE, RD_A, RD_B, CAPT, WRITE, DONE.
REQ-019 In IDLE with valid=1: latch mode, addr_a, addr_b and addr_c; clear idx; go to RD_A next cycle.
REQ-020 Inputs valid, mode and addr_* are ignored in all states except IDLE; input changes do not affect an operation in progress.
REQ-021 RD_A: raddress = addr_a+idx; go to RD_B.
REQ-022 RD_B: raddress = addr_b+idx; register a_q <= data_rd; go to CAPT.
REQ-023 CAPT: register b_q <= data_rd; go to WRITE.
REQ-024 WRITE: we_n=0, waddress = addr_c+idx, data_wr = clip(f(a_q,b_q)); we_n=1 in every other state.
REQ-025 After WRITE: if idx == HYPERVECTOR_DIMENSIONS-1, go to DONE; otherwise idx++ and go to RD_A.
REQ-026 DONE: done=1 for exactly one cycle; go to IDLE; a valid seen in DONE is ignored.
REQ-027 Throughput is 4 cycles per element; latency from valid sampled to the done pulse is 4*HYPERVECTOR_DIMENSIONS+1 cycles.
REQ-028 Address sums wrap modulo 2^ADDR_W; there is no overflow flag.
REQ-029 ADD and SUB are computed at DATA_W+1 bits and MUL at 2*DATA_W bits, all signed, before clipping; no intermediate truncation.
REQ-030 clip(x) = CUT_NEG if x<CUT_NEG, CUT_POS if x>CUT_POS, else x. PASS_A is also clipped.
REQ-031 Overlapping A/C or B/C regions are legal; element i is read before element i is written.
REQ-032 raddress, waddress and data_wr are 0 whenever their state does not drive them.

Reset
REQ-033 reset_n=0 at a clock edge forces IDLE, idx=0, a_q=b_q=0, we_n=1, raddress=waddress=data_wr=0, busy=0, done=0.
REQ-034 Reset mid-operation aborts without completing the pending write and without a done pulse; writes already performed are not undone.

Configuration
REQ-035 Macro HV_SAT_COUNT_EN defined: the block adds output sat_count (ADDR_W+1 bits), cleared at start and incremented on each WRITE whose pre-clip value was outside [CUT_NEG,CUT_POS]. sat_count holds its value after done until the next start.
REQ-036 Macro HV_SAT_COUNT_EN undefined: the sat_count port and its logic are absent; all other behaviour is identical.

Structure
REQ-037 Package hv_pkg holds the hv_mode_e enum (ADD/SUB/MUL/PASS_A), the FSM state enum and the default ADDR_W/DATA_W constants.
REQ-038 One combinational sub-module, hv_cut_alu, computes f and the clip and outputs the saturated flag; the FSM, counter and memory interface stay in hv_elementwise_alu.

Verification
REQ-039 All memory words = 25, mode ADD, DIM=1000, addr_a/b/c = 0/1024/2048 -> words 2048..3047 = 1, done after 4001 cycles, sat_count=1000.
REQ-040 A=25, B=25, mode SUB -> every C element = 0, sat_count=0.
REQ-041 A=-3, B=5, mode MUL -> C = -1; with CUT_NEG=-20, CUT_POS=20 -> C = -15.
REQ-042 valid pulsed again while busy, with different addr_c -> ignored: exactly one done, and the original region only is written.
REQ-043 reset_n driven low at element 500 -> next cycle IDLE, busy=0, no done; words 2548..3047 are unchanged.
REQ-044 addr_c = 2^21-2, DIM=4 -> writes go to 2^21-2, 2^21-1, 0, 1.
